// File: rtl/na_conf_pkg.sv
// Shared address map and FSM encoding for the network-adapter configuration
// reader and its responder.
package na_conf_pkg;

    localparam logic [15:0] ADR_TILE_ID   = 16'h0000;
    localparam logic [15:0] ADR_NUM_TILES = 16'h0004;
    localparam logic [15:0] ADR_CONF      = 16'h000C;
    localparam logic [15:0] ADR_CORE_BASE = 16'h0010;
    localparam logic [15:0] ADR_NUMCTS    = 16'h0028;
    localparam logic [15:0] ADR_CT_LIST   = 16'h0200;

    localparam int CONF_MPSIMPLE = 0;
    localparam int CONF_DMA      = 1;

    localparam int NUM_FIXED = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP,
        ST_DONE,
        ST_FAIL
    } state_e;

    function automatic logic [15:0] fixed_adr(input logic [2:0] step);
        case (step)
            3'd0:    fixed_adr = ADR_TILE_ID;
            3'd1:    fixed_adr = ADR_NUM_TILES;
            3'd2:    fixed_adr = ADR_CONF;
            3'd3:    fixed_adr = ADR_CORE_BASE;
            default: fixed_adr = ADR_NUMCTS;
        endcase
    endfunction

endpackage

// File: rtl/na_conf_ctlist_ram.sv
// Compute-tile list cache: one synchronous write port, one asynchronous read port.
module na_conf_ctlist_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_idx,
    input  logic [15:0]   wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [15:0]   rd_data
);

    logic [15:0] mem [DEPTH];

    // NOTE: the array has no reset; readers gate it with the valid count, so stale words never escape.
    always_ff @(posedge clk) begin
        if (we) mem[wr_idx] <= wr_data;
    end

    assign rd_data = (32'(rd_idx) < DEPTH) ? mem[rd_idx] : 16'h0000;

endmodule

// File: rtl/na_conf_reader.sv
// Walks the NA configuration space over a Wishbone-classic read port and
// caches tile id, tile count, config bits, core base and the compute-tile list.
module na_conf_reader
    import na_conf_pkg::*;
#(
    parameter int DW         = 32,
    parameter int MAX_CTS    = 64,
    parameter int RETRIES    = 4,
    parameter int AUTO_START = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [15:0]   wb_adr_o,
    output logic          wb_we_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_rty_i,
    input  logic          wb_err_i,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [DW-1:0] tile_id,
    output logic [DW-1:0] num_tiles,
    output logic          conf_mpsimple,
    output logic          conf_dma,
    output logic [DW-1:0] core_base,
    output logic [6:0]    num_cts,
    input  logic [5:0]    ct_idx,
    output logic [15:0]   ct_data
);

    state_e      state;
    logic [2:0]  step;
    logic        in_list;
    logic [5:0]  ct_cnt;
    logic [7:0]  retry_cnt;
    logic        advance;
    logic        auto_pending;

    logic        start_scan;
    logic        list_we;
    logic [15:0] list_wdata;
    logic [15:0] list_rdata;
    logic [6:0]  next_idx;
    logic [6:0]  numcts_sat;

    assign wb_we_o  = 1'b0;
    assign wb_dat_o = '0;

    assign start_scan = (start || auto_pending) &&
                        (state == ST_IDLE || state == ST_DONE || state == ST_FAIL);

    // err outranks ack, so a list write happens only on a clean ack.
    assign list_we    = (state == ST_REQ) && in_list && wb_ack_i && !wb_err_i;
    assign list_wdata = wb_adr_o[1] ? wb_dat_i[15:0] : wb_dat_i[31:16];
    assign next_idx   = {1'b0, ct_cnt} + 7'd1;
    assign numcts_sat = (wb_dat_i > DW'(MAX_CTS)) ? 7'(MAX_CTS) : wb_dat_i[6:0];

    na_conf_ctlist_ram #(
        .DEPTH (MAX_CTS),
        .AW    (6)
    ) u_ctlist (
        .clk     (clk),
        .we      (list_we),
        .wr_idx  (ct_cnt),
        .wr_data (list_wdata),
        .rd_idx  (ct_idx),
        .rd_data (list_rdata)
    );

    assign ct_data = ({1'b0, ct_idx} < num_cts) ? list_rdata : 16'h0000;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            step          <= 3'd0;
            in_list       <= 1'b0;
            ct_cnt        <= 6'd0;
            retry_cnt     <= 8'd0;
            advance       <= 1'b0;
            auto_pending  <= (AUTO_START != 0);
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_adr_o      <= 16'h0000;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            tile_id       <= '0;
            num_tiles     <= '0;
            conf_mpsimple <= 1'b0;
            conf_dma      <= 1'b0;
            core_base     <= '0;
            num_cts       <= 7'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start_scan) begin
                        state        <= ST_REQ;
                        step         <= 3'd0;
                        in_list      <= 1'b0;
                        ct_cnt       <= 6'd0;
                        retry_cnt    <= 8'd0;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        busy         <= 1'b1;
                        wb_cyc_o     <= 1'b1;
                        wb_stb_o     <= 1'b1;
                        wb_adr_o     <= ADR_TILE_ID;
                        auto_pending <= 1'b0;
                    end
                end

                ST_REQ: begin
                    if (wb_err_i) begin
                        state    <= ST_FAIL;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                    end else if (wb_ack_i) begin
                        state    <= ST_GAP;
                        advance  <= 1'b1;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (!in_list) begin
                            case (step)
                                3'd0: tile_id   <= wb_dat_i;
                                3'd1: num_tiles <= wb_dat_i;
                                3'd2: begin
                                    conf_mpsimple <= wb_dat_i[CONF_MPSIMPLE];
                                    conf_dma      <= wb_dat_i[CONF_DMA];
                                end
                                3'd3: core_base <= wb_dat_i;
                                default: num_cts <= numcts_sat;
                            endcase
                        end
                    end else if (wb_rty_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (retry_cnt < 8'(RETRIES)) begin
                            state     <= ST_GAP;
                            advance   <= 1'b0;
                            retry_cnt <= retry_cnt + 8'd1;
                        end else begin
                            state <= ST_FAIL;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end

                ST_GAP: begin
                    if (!advance) begin
                        state    <= ST_REQ;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                    end else if (!in_list && step != 3'(NUM_FIXED - 1)) begin
                        state     <= ST_REQ;
                        step      <= step + 3'd1;
                        wb_adr_o  <= fixed_adr(step + 3'd1);
                        retry_cnt <= 8'd0;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                    end else if (!in_list && num_cts != 7'd0) begin
                        state     <= ST_REQ;
                        in_list   <= 1'b1;
                        ct_cnt    <= 6'd0;
                        wb_adr_o  <= ADR_CT_LIST;
                        retry_cnt <= 8'd0;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                    end else if (in_list && next_idx < num_cts) begin
                        state     <= ST_REQ;
                        ct_cnt    <= ct_cnt + 6'd1;
                        wb_adr_o  <= ADR_CT_LIST + {8'b0, next_idx, 1'b0};
                        retry_cnt <= 8'd0;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_na_conf_reader.sv
// Directed bench: a combinational responder model drives two readers
// (default parameters, and RETRIES=1 without auto start).
module tb_na_conf_reader;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    // Responder register image
    logic [31:0] r_tile, r_ntiles, r_conf, r_core, r_numcts;
    logic [15:0] lst [64];
    logic [15:0] rty_addr, err_addr;
    int          rty_limit;
    logic        err_en;

    // Instance 0 (defaults)
    logic        start0, cyc0, stb0, we0, ack0, rty0, err0, busy0, done0, error0, mps0, dma0;
    logic [15:0] adr0, ct_data0;
    logic [31:0] dato0, dati0, tile_id0, num_tiles0, core_base0;
    logic [6:0]  num_cts0;
    logic [5:0]  ct_idx0;
    int          cnt04_0, hits0, rty_seen0;
    logic [15:0] last0;

    // Instance 1 (RETRIES=1, AUTO_START=0)
    logic        start1, cyc1, stb1, we1, ack1, rty1, err1, busy1, done1, error1, mps1, dma1;
    logic [15:0] adr1, ct_data1;
    logic [31:0] dato1, dati1, tile_id1, num_tiles1, core_base1;
    logic [6:0]  num_cts1;
    logic [5:0]  ct_idx1;
    int          rty_seen1;

    na_conf_reader u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .wb_cyc_o(cyc0), .wb_stb_o(stb0), .wb_adr_o(adr0), .wb_we_o(we0), .wb_dat_o(dato0),
        .wb_dat_i(dati0), .wb_ack_i(ack0), .wb_rty_i(rty0), .wb_err_i(err0),
        .busy(busy0), .done(done0), .error(error0),
        .tile_id(tile_id0), .num_tiles(num_tiles0), .conf_mpsimple(mps0), .conf_dma(dma0),
        .core_base(core_base0), .num_cts(num_cts0), .ct_idx(ct_idx0), .ct_data(ct_data0)
    );

    na_conf_reader #(.RETRIES(1), .AUTO_START(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .wb_cyc_o(cyc1), .wb_stb_o(stb1), .wb_adr_o(adr1), .wb_we_o(we1), .wb_dat_o(dato1),
        .wb_dat_i(dati1), .wb_ack_i(ack1), .wb_rty_i(rty1), .wb_err_i(err1),
        .busy(busy1), .done(done1), .error(error1),
        .tile_id(tile_id1), .num_tiles(num_tiles1), .conf_mpsimple(mps1), .conf_dma(dma1),
        .core_base(core_base1), .num_cts(num_cts1), .ct_idx(ct_idx1), .ct_data(ct_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_word(input logic [15:0] a);
        logic [15:0] e;
        if (a >= 16'h0200) begin
            e = lst[6'((a - 16'h0200) >> 1)];
            return a[1] ? {16'hBEEF, e} : {e, 16'hDEAD};
        end
        case (a)
            16'h0000: return r_tile;
            16'h0004: return r_ntiles;
            16'h000C: return r_conf;
            16'h0010: return r_core;
            16'h0028: return r_numcts;
            default:  return 32'hBAD0_BAD0;
        endcase
    endfunction

    always_comb dati0 = rd_word(adr0);
    always_comb dati1 = rd_word(adr1);

    assign rty0 = cyc0 && stb0 && adr0 == rty_addr && rty_seen0 < rty_limit;
    assign err0 = cyc0 && stb0 && err_en && adr0 == err_addr;
    assign ack0 = cyc0 && stb0 && !rty0;
    assign rty1 = cyc1 && stb1 && adr1 == rty_addr && rty_seen1 < rty_limit;
    assign err1 = cyc1 && stb1 && err_en && adr1 == err_addr;
    assign ack1 = cyc1 && stb1 && !rty1;

    always @(posedge clk) begin
        if (!rst || start0) begin
            cnt04_0   <= 0;
            hits0     <= 0;
            last0     <= 16'h0000;
            rty_seen0 <= 0;
        end else if (cyc0 && stb0) begin
            last0 <= adr0;
            if (adr0 >= 16'h0200) hits0 <= hits0 + 1;
            if (adr0 == 16'h0004) cnt04_0 <= cnt04_0 + 1;
            if (rty0) rty_seen0 <= rty_seen0 + 1;
        end
    end

    always @(posedge clk) begin
        if (!rst || start1) rty_seen1 <= 0;
        else if (rty1) rty_seen1 <= rty_seen1 + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] tile, ntiles, conf, core, numcts;
        logic [15:0] l0, l1, l2;
        int          exp_cyc;
        logic [6:0]  exp_num;
        logic [15:0] exp_last;
        logic        exp_mps, exp_dma;
    } scan_vec_t;

    task automatic load(input scan_vec_t v);
        r_tile   = v.tile;
        r_ntiles = v.ntiles;
        r_conf   = v.conf;
        r_core   = v.core;
        r_numcts = v.numcts;
        for (int i = 0; i < 64; i++) lst[i] = 16'hA000 + 16'(i);
        lst[0] = v.l0;
        lst[1] = v.l1;
        lst[2] = v.l2;
    endtask

    task automatic pulse_start(input bit which);
        @(negedge clk);
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Counts falling edges until done or error appears, bounded by max.
    task automatic wait_end(input bit which, input int max, output int n);
        n = 0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (which ? (done1 || error1) : (done0 || error0)) break;
        end
    endtask

    scan_vec_t vecs [5];
    int        n;
    int        tot;

    initial begin
        tests = 0; fails = 0;
        start0 = 1'b0; start1 = 1'b0;
        ct_idx0 = 6'd0; ct_idx1 = 6'd0;
        rty_addr = 16'h0004; rty_limit = 0;
        err_addr = 16'h0202; err_en = 1'b0;

        //         tile          ntiles        conf          core          numcts  l0       l1       l2       cyc  num  last      mps   dma
        vecs[0] = '{32'd3,        32'd8,        32'h2,        32'h20,       32'd3,   16'd5,   16'd2,   16'd0,   16,  7'd3,  16'h0204, 1'b0, 1'b1};
        vecs[1] = '{32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hA5A50000, 32'd0,   16'h1111,16'h2222,16'h3333,10,  7'd0,  16'h0028, 1'b1, 1'b0};
        vecs[2] = '{32'hCAFE,     32'd16,       32'h3,        32'h40,       32'd100, 16'hFFFF,16'h0001,16'h8000,138, 7'd64, 16'h027E, 1'b1, 1'b1};
        vecs[3] = '{32'd7,        32'd64,       32'h1,        32'h1000,     32'd64,  16'd9,   16'd8,   16'd7,   138, 7'd64, 16'h027E, 1'b1, 1'b0};
        vecs[4] = '{32'd1,        32'd2,        32'h0,        32'h80,       32'd1,   16'hBEEF,16'd1,   16'd2,   12,  7'd1,  16'h0200, 1'b0, 1'b0};

        load(vecs[0]);
        rst = 1'b0;
        #12;
        check("rst cyc", cyc0, 0);
        check("rst stb", stb0, 0);
        check("rst adr", adr0, 0);
        check("rst we", we0, 0);
        check("rst busy", busy0, 0);
        check("rst done", done0, 0);
        check("rst error", error0, 0);
        check("rst tile_id", tile_id0, 0);
        check("rst num_cts", num_cts0, 0);
        check("rst ct_data", ct_data0, 0);

        // Auto start straight out of reset.
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (!cyc0 && n < 10) begin @(negedge clk); n++; end
        check("auto req delay", n, 1);
        check("auto req adr", adr0, 16'h0000);
        check("auto busy", busy0, 1);
        wait_end(1'b0, 300, n);
        check("auto cycles", n, 16);
        check("auto done", done0, 1);
        check("auto tile_id", tile_id0, 3);
        check("idle dut1 busy", busy1, 0);
        check("idle dut1 cyc", cyc1, 0);

        // Table-driven clean scans.
        for (int k = 0; k < 5; k++) begin
            load(vecs[k]);
            pulse_start(1'b0);
            check($sformatf("v%0d first adr", k), adr0, 16'h0000);
            wait_end(1'b0, 300, n);
            check($sformatf("v%0d cycles", k), n, vecs[k].exp_cyc);
            check($sformatf("v%0d done", k), done0, 1);
            check($sformatf("v%0d error", k), error0, 0);
            check($sformatf("v%0d busy", k), busy0, 0);
            check($sformatf("v%0d cyc", k), cyc0, 0);
            check($sformatf("v%0d tile_id", k), tile_id0, vecs[k].tile);
            check($sformatf("v%0d num_tiles", k), num_tiles0, vecs[k].ntiles);
            check($sformatf("v%0d core_base", k), core_base0, vecs[k].core);
            check($sformatf("v%0d mpsimple", k), mps0, vecs[k].exp_mps);
            check($sformatf("v%0d dma", k), dma0, vecs[k].exp_dma);
            check($sformatf("v%0d num_cts", k), num_cts0, vecs[k].exp_num);
            check($sformatf("v%0d last adr", k), last0, vecs[k].exp_last);
            check($sformatf("v%0d list reads", k), hits0, 32'(vecs[k].exp_num));
            for (int i = 0; i < 64; i++) begin
                ct_idx0 = 6'(i);
                #1;
                check($sformatf("v%0d ct[%0d]", k, i), ct_data0,
                      (i < int'(vecs[k].exp_num)) ? 32'(lst[i]) : 32'h0);
            end
        end

        // Two retries on 0x04, default RETRIES: recovers.
        r_numcts = 32'd0;
        rty_limit = 2;
        pulse_start(1'b0);
        wait_end(1'b0, 300, n);
        check("rty cycles", n, 14);
        check("rty 0x04 issues", cnt04_0, 3);
        check("rty done", done0, 1);
        check("rty error", error0, 0);
        check("rty num_tiles", num_tiles0, r_ntiles);

        // Same stimulus with RETRIES=1: gives up.
        pulse_start(1'b1);
        wait_end(1'b1, 300, n);
        check("rty1 cycles", n, 5);
        check("rty1 error", error1, 1);
        check("rty1 done", done1, 0);
        check("rty1 cyc", cyc1, 0);
        check("rty1 stb", stb1, 0);
        check("rty1 busy", busy1, 0);
        rty_limit = 0;

        // err (together with ack) on list entry 1 at 0x202.
        load(vecs[0]);
        lst[0] = 16'h0A0A;
        err_en = 1'b1;
        pulse_start(1'b0);
        wait_end(1'b0, 300, n);
        check("err cycles", n, 13);
        check("err error", error0, 1);
        check("err done", done0, 0);
        check("err busy", busy0, 0);
        check("err cyc", cyc0, 0);
        check("err last adr", last0, 16'h0202);
        ct_idx0 = 6'd0;
        #1;
        check("err ct[0]", ct_data0, 16'h0A0A);
        err_en = 1'b0;

        // start while busy, and start on the DONE transition edge, are both ignored.
        load(vecs[0]);
        pulse_start(1'b0);
        tot = 0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            start0 = (c == 6) || (c == 15);
            if (c == 15) check("busy-start done@15", done0, 0);
            if (c == 16) check("busy-start done@16", done0, 1);
            if (c == 17) tot = tot + (cyc0 ? 1 : 0);
        end
        start0 = 1'b0;
        check("done-edge start no req", tot, 0);
        check("done-edge start done", done0, 1);
        check("done-edge start busy", busy0, 0);
        check("done-edge start cyc", cyc0, 0);

        // Asynchronous reset while the 0x10 read is on the bus.
        pulse_start(1'b0);
        n = 0;
        while (!(cyc0 && adr0 == 16'h0010) && n < 20) begin @(negedge clk); n++; end
        check("mid-rst reached 0x10", adr0, 16'h0010);
        #2 rst = 1'b0;
        #1;
        check("mid-rst cyc", cyc0, 0);
        check("mid-rst stb", stb0, 0);
        check("mid-rst adr", adr0, 0);
        check("mid-rst busy", busy0, 0);
        check("mid-rst done", done0, 0);
        check("mid-rst tile_id", tile_id0, 0);
        check("mid-rst num_tiles", num_tiles0, 0);
        check("mid-rst num_cts", num_cts0, 0);
        check("mid-rst dma", dma0, 0);
        check("mid-rst ct_data", ct_data0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post-rst req cyc", cyc0, 1);
        check("post-rst req adr", adr0, 16'h0000);
        wait_end(1'b0, 300, n);
        check("post-rst done", done0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
